// File: rtl/output_max_finder.sv
// ---------------------------------------------------------------------------
// output_max_finder
//
// Classification stage behind the final neuron layer. Each neuron output is
// captured into its own slot when that neuron's valid bit is high. Slots may
// fill on different cycles. Once every slot holds data, the block scans the
// slots one per clock and reports the index and value of the largest signed
// output as a single-cycle result pulse.
//
// Handshake: valid_in[k] is a fire-and-forget strobe with no ready. A strobe
// seen in IDLE is always accepted. A strobe seen while busy is dropped and sets
// the sticky overrun flag. valid_out is a one-cycle pulse with no
// backpressure. max_index and max_value are valid while it is high and keep
// their values until the next result.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   neuron_in  concatenated outputs; neuron k at [k*data_width +: data_width]
//   valid_in   per-neuron valid strobes
//   max_index  index of the winning neuron
//   max_value  value of the winning neuron (signed)
//   valid_out  one-cycle result pulse
//   busy       high while scanning
//   overrun    sticky, set when a valid_in bit arrives during a scan
// ---------------------------------------------------------------------------
module output_max_finder #(
   parameter int num_inputs  = 10,
   parameter int data_width  = 16,
   parameter int index_width = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [num_inputs*data_width-1:0] neuron_in,
   input  logic [num_inputs-1:0]            valid_in,
   output logic [index_width-1:0]           max_index,
   output logic [data_width-1:0]            max_value,
   output logic                             valid_out,
   output logic                             busy,
   output logic                             overrun
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [index_width-1:0] last_idx = index_width'(num_inputs - 1);

   state_t                 state;
   logic [data_width-1:0]  slot_q [num_inputs];
   logic [num_inputs-1:0]  pend;
   logic [index_width-1:0] scan_idx;
   logic [index_width-1:0] best_idx;
   logic [data_width-1:0]  best_val;

   logic                   all_held;
   logic [data_width-1:0]  cand;
   logic                   take;
   logic [data_width-1:0]  next_val;
   logic [index_width-1:0] next_idx;

   // The set is complete when every slot is either already held or arriving
   // on this edge.
   assign all_held = &(pend | valid_in);

   // Running-maximum step. The first element always seeds the best value.
   // A strict greater-than keeps the lower index on ties.
   always_comb begin
      cand     = slot_q[scan_idx];
      take     = (scan_idx == '0) || ($signed(cand) > $signed(best_val));
      next_val = take ? cand : best_val;
      next_idx = take ? scan_idx : best_idx;
   end

   // The slot storage has no reset because its contents do not matter until
   // pend says a slot has been written. Writes happen only in IDLE, so the
   // slots stay stable while a scan reads them.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         for (int k = 0; k < num_inputs; k++) begin
            if (valid_in[k]) begin
               slot_q[k] <= neuron_in[k*data_width +: data_width];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pend      <= '0;
         scan_idx  <= '0;
         best_idx  <= '0;
         best_val  <= '0;
         max_index <= '0;
         max_value <= '0;
         valid_out <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (all_held) begin
                  pend     <= '0;
                  scan_idx <= '0;
                  busy     <= 1'b1;
                  state    <= SCAN;
               end else begin
                  pend <= pend | valid_in;
               end
            end
            SCAN: begin
               if (|valid_in) begin
                  overrun <= 1'b1;
               end
               best_val <= next_val;
               best_idx <= next_idx;
               scan_idx <= scan_idx + 1'b1;
               if (scan_idx == last_idx) begin
                  max_index <= next_idx;
                  max_value <= next_val;
                  valid_out <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
